// File: rtl/s_cpu_cycle_error_log_if.sv
// Checker verdict strobe and show-ahead FIFO read port of the SPC700 cycle error log.
interface s_cpu_cycle_error_log_if;
  logic        chk_valid;
  logic        chk_error;
  logic [7:0]  chk_op;
  logic [15:0] chk_pc;
  logic [3:0]  chk_cycles;
  logic [3:0]  chk_ref;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ack;

  modport master (
    output chk_valid, chk_error, chk_op, chk_pc, chk_cycles, chk_ref, rd_ack,
    input  rd_valid, rd_data
  );

  modport slave (
    input  chk_valid, chk_error, chk_op, chk_pc, chk_cycles, chk_ref, rd_ack,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/s_cpu_cycle_error_log.sv
// Counts checker verdicts, logs failing instructions into a show-ahead FIFO
// and latches the first failure in sticky registers.
module s_cpu_cycle_error_log #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       arm,
  s_cpu_cycle_error_log_if.slave     bus,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           err_count,
  output logic [CNT_W-1:0]           instr_count,
  output logic                       first_valid,
  output logic [31:0]                first_entry
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic        accept;
  logic        fail;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] entry;

  always_comb begin
    accept = bus.chk_valid & arm;
    fail   = accept & bus.chk_error;
    entry  = {bus.chk_op, bus.chk_pc, bus.chk_cycles, bus.chk_ref};
    empty  = (fifo_level == '0);
    full   = (fifo_level == FULL_LVL);
    pop    = bus.rd_ack & ~empty;
    // A pop frees the slot in the same edge, so a push into a full FIFO survives.
    push   = fail & (~full | pop);
    drop   = fail & full & ~pop;
  end

  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + (AW+1)'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      instr_count <= '0;
      err_count   <= '0;
      first_valid <= 1'b0;
      first_entry <= '0;
    end else begin
      if (accept && instr_count != '1) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (fail && err_count != '1) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (fail && !first_valid) begin
        first_valid <= 1'b1;
        first_entry <= entry;
      end
    end
  end

endmodule

// File: tb/tb_s_cpu_cycle_error_log.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_s_cpu_cycle_error_log;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, clear, arm;

  s_cpu_cycle_error_log_if ifa ();
  s_cpu_cycle_error_log_if ifb ();

  logic [LW-1:0] fifo_level;
  logic          overflow, first_valid;
  logic [15:0]   err_count, instr_count;
  logic [31:0]   first_entry;

  logic [LW-1:0] s_level;
  logic          s_overflow, s_first_valid;
  logic [3:0]    s_err_count, s_instr_count;
  logic [31:0]   s_first_entry;

  assign ifb.chk_valid  = ifa.chk_valid;
  assign ifb.chk_error  = ifa.chk_error;
  assign ifb.chk_op     = ifa.chk_op;
  assign ifb.chk_pc     = ifa.chk_pc;
  assign ifb.chk_cycles = ifa.chk_cycles;
  assign ifb.chk_ref    = ifa.chk_ref;
  assign ifb.rd_ack     = ifa.rd_ack;

  s_cpu_cycle_error_log #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .arm(arm), .bus(ifa),
    .fifo_level(fifo_level), .overflow(overflow), .err_count(err_count),
    .instr_count(instr_count), .first_valid(first_valid), .first_entry(first_entry)
  );

  s_cpu_cycle_error_log #(.DEPTH(DEPTH), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .arm(arm), .bus(ifb),
    .fifo_level(s_level), .overflow(s_overflow), .err_count(s_err_count),
    .instr_count(s_instr_count), .first_valid(s_first_valid), .first_entry(s_first_entry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int          m_instr, m_err;
  bit          m_ovf, m_fv;
  logic [31:0] m_first;

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_instr = 0;
    m_err   = 0;
    m_ovf   = 1'b0;
    m_fv    = 1'b0;
    m_first = '0;
  endfunction

  function automatic void model(input bit v, e, a, k, c, input logic [31:0] ent);
    bit acc;
    logic [31:0] dummy;
    if (c) begin
      model_clear();
      return;
    end
    acc = v && a;
    if (acc) m_instr++;
    if (acc && e) begin
      m_err++;
      if (!m_fv) begin
        m_fv    = 1'b1;
        m_first = ent;
      end
    end
    if (k && mq.size() > 0) dummy = mq.pop_front();
    if (acc && e) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic step(input bit v, e, a, k, c, input logic [7:0] op,
                      input logic [15:0] pc, input logic [3:0] cy, input logic [3:0] rf);
    ifa.chk_valid  = v;
    ifa.chk_error  = e;
    ifa.chk_op     = op;
    ifa.chk_pc     = pc;
    ifa.chk_cycles = cy;
    ifa.chk_ref    = rf;
    ifa.rd_ack     = k;
    arm            = a;
    clear          = c;
    @(posedge clk);
    model(v, e, a, k, c, {op, pc, cy, rf});
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.chk_valid = 1'b0; ifa.chk_error = 1'b0; ifa.rd_ack = 1'b0;
    ifa.chk_op = '0; ifa.chk_pc = '0; ifa.chk_cycles = '0; ifa.chk_ref = '0;
    arm = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    checks++;
    if (ifa.rd_valid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0 ||
        err_count !== 16'd0 || instr_count !== 16'd0 || first_valid !== 1'b0 ||
        first_entry !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rd_valid=%b level=%0d ovf=%b err=%0d instr=%0d fv=%b first=%h, required all zero",
               ifa.rd_valid, fifo_level, overflow, err_count, instr_count, first_valid, first_entry);
    end
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i), 16'(i), 4'h1, 4'h2);
    checks++;
    if (instr_count !== 16'd5 || err_count !== 16'd0 || ifa.rd_valid !== 1'b0 || first_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_events: instr=%0d err=%0d rd_valid=%b fv=%b, required 5 0 0 0",
               instr_count, err_count, ifa.rd_valid, first_valid);
    end
  endtask

  task automatic test_single_failure();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE8, 16'h0400, 4'd2, 4'd2);
    checks++;
    if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== 32'hE8040022) begin
      errors++;
      $display("FAIL single_push: rd_valid=%b rd_data=%h, required 1 e8040022", ifa.rd_valid, ifa.rd_data);
    end
    checks++;
    if (first_valid !== 1'b1 || first_entry !== 32'hE8040022 || err_count !== 16'd1 || fifo_level !== LW'(1)) begin
      errors++;
      $display("FAIL single_first: fv=%b first=%h err=%0d level=%0d, required 1 e8040022 1 1",
               first_valid, first_entry, err_count, fifo_level);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3F, 16'(i), 4'd5, 4'd3);
    checks++;
    if (fifo_level !== LW'(8) || overflow !== 1'b1 || err_count !== 16'd10) begin
      errors++;
      $display("FAIL overflow_state: level=%0d ovf=%b err=%0d, required 8 1 10", fifo_level, overflow, err_count);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ifa.rd_valid !== 1'b1 || ifa.rd_data[23:8] !== 16'(i)) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: rd_valid=%b pc=%h, required 1 %h", i, ifa.rd_valid, ifa.rd_data[23:8], 16'(i));
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0);
    end
    checks++;
    if (fifo_level !== '0 || ifa.rd_valid !== 1'b0 || first_entry[23:8] !== 16'h0000 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after: level=%0d rd_valid=%b first_pc=%h ovf=%b, required 0 0 0000 1",
               fifo_level, ifa.rd_valid, first_entry[23:8], overflow);
    end
  endtask

  task automatic test_full_push_pop();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0010 + 16'(i), 4'd1, 4'd4);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 16'h0055, 4'd6, 4'd7);
    checks++;
    if (fifo_level !== LW'(8) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d ovf=%b, required 8 0", fifo_level, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ifa.rd_data !== mq[0]) begin
        errors++;
        $display("FAIL full_drain[%0d]: rd_data=%h, required %h", i, ifa.rd_data, mq[0]);
      end
      if (i == 7) begin
        checks++;
        if (ifa.rd_data !== 32'h55005567) begin
          errors++;
          $display("FAIL full_last: rd_data=%h, required 55005567", ifa.rd_data);
        end
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0);
    end
  endtask

  task automatic test_empty_ack();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 4'h0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 16'h1234, 4'd3, 4'd9);
    checks++;
    if (fifo_level !== LW'(1) || ifa.rd_valid !== 1'b1 || ifa.rd_data !== 32'hA1123439) begin
      errors++;
      $display("FAIL empty_ack_push: level=%0d rd_valid=%b data=%h, required 1 1 a1123439",
               fifo_level, ifa.rd_valid, ifa.rd_data);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0);
    checks++;
    if (fifo_level !== '0 || ifa.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_ack_pop: level=%0d rd_valid=%b, required 0 0", fifo_level, ifa.rd_valid);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0);
    checks++;
    if (fifo_level !== '0) begin
      errors++;
      $display("FAIL ack_underflow: level=%0d, required 0", fifo_level);
    end
  endtask

  task automatic test_arm_clear();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 4'h0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 16'h0100, 4'd1, 4'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 16'h0200, 4'd3, 4'd4);
    checks++;
    if (instr_count !== 16'd1 || err_count !== 16'd1 || fifo_level !== LW'(1) || ifa.rd_data !== 32'h11010012) begin
      errors++;
      $display("FAIL disarmed: instr=%0d err=%0d level=%0d data=%h, required 1 1 1 11010012",
               instr_count, err_count, fifo_level, ifa.rd_data);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 16'h0300, 4'd5, 4'd6);
    checks++;
    if (ifa.rd_valid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0 || err_count !== 16'd0 ||
        instr_count !== 16'd0 || first_valid !== 1'b0 || first_entry !== 32'd0) begin
      errors++;
      $display("FAIL clear_priority: rd_valid=%b level=%0d ovf=%b err=%0d instr=%0d fv=%b first=%h, required all zero",
               ifa.rd_valid, fifo_level, overflow, err_count, instr_count, first_valid, first_entry);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 16'(i), 4'd8, 4'd1);
    checks++;
    if (s_err_count !== 4'd15 || s_instr_count !== 4'd15 || err_count !== 16'd20) begin
      errors++;
      $display("FAIL saturation: sat_err=%0d sat_instr=%0d err=%0d, required 15 15 20",
               s_err_count, s_instr_count, err_count);
    end
  endtask

  task automatic test_random();
    bit v, e, a, k, c;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 4'h0, 4'h0);
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 1) != 0);
      a = ($urandom_range(0, 9) != 0);
      k = ($urandom_range(0, 9) < 4);
      c = ($urandom_range(0, 199) == 0);
      step(v, e, a, k, c, 8'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      checks++;
      if (ifa.rd_valid !== (mq.size() > 0) || fifo_level !== LW'(mq.size()) ||
          (mq.size() > 0 && ifa.rd_data !== mq[0])) begin
        errors++;
        $display("FAIL rand_fifo[%0d]: rd_valid=%b level=%0d data=%h, required %b %0d %h",
                 n, ifa.rd_valid, fifo_level, ifa.rd_data, mq.size() > 0, mq.size(),
                 (mq.size() > 0) ? mq[0] : 32'h0);
      end
      checks++;
      if (overflow !== m_ovf || err_count !== 16'(sat(m_err, 16)) || instr_count !== 16'(sat(m_instr, 16)) ||
          first_valid !== m_fv || first_entry !== m_first) begin
        errors++;
        $display("FAIL rand_status[%0d]: ovf=%b err=%0d instr=%0d fv=%b first=%h, required %b %0d %0d %b %h",
                 n, overflow, err_count, instr_count, first_valid, first_entry,
                 m_ovf, sat(m_err, 16), sat(m_instr, 16), m_fv, m_first);
      end
      checks++;
      if (s_err_count !== 4'(sat(m_err, 4)) || s_instr_count !== 4'(sat(m_instr, 4)) ||
          s_level !== LW'(mq.size()) || ifb.rd_valid !== (mq.size() > 0)) begin
        errors++;
        $display("FAIL rand_sat[%0d]: err=%0d instr=%0d level=%0d, required %0d %0d %0d",
                 n, s_err_count, s_instr_count, s_level, sat(m_err, 4), sat(m_instr, 4), mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_failure();
    test_overflow();
    test_full_push_pop();
    test_empty_ack();
    test_arm_clear();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
